// File: rtl/mem_port_arbiter_pkg.sv
// Shared types, widths and helpers for the two-port data-memory arbiter.
package mem_port_arbiter_pkg;

    // Arbiter FSM states; the encoding matches the ARB_* values used elsewhere in the project.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    // Port identifiers as they appear on GRANT_ID.
    typedef enum logic {
        PORT_CTRL = 1'b0,
        PORT_DMA  = 1'b1
    } port_id_t;

    // Width of the latency counter and of the starvation counter.
    localparam int CNT_W = 4;

    // Saturation value of the starvation counter.
    localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;

    // Reload value of the latency counter for a given strobe width.
    // Out-of-range widths are clamped so the counter never wraps.
    function automatic logic [CNT_W-1:0] lat_load(input int unsigned lat);
        logic [CNT_W-1:0] load;
        if (lat == 0) begin
            load = '0;
        end else if (lat > 15) begin
            load = 4'd14;
        end else begin
            load = CNT_W'(lat - 1);
        end
        return load;
    endfunction

    // Starvation threshold clamped to what the 4-bit counter can reach.
    function automatic logic [CNT_W-1:0] starve_threshold(input int unsigned limit);
        logic [CNT_W-1:0] thr;
        if (limit > 15) begin
            thr = CNT_MAX;
        end else begin
            thr = CNT_W'(limit);
        end
        return thr;
    endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive port-0 wins while port 1 is waiting.
// Raises force1 once the count reaches the configured limit so that the
// next tie goes to port 1.
module mem_arb_starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic grant0,
    input  logic grant1,
    input  logic req1,
    input  logic clr,
    output logic force1
);

    localparam logic [CNT_W-1:0] THRESHOLD = starve_threshold(STARVE_LIMIT);
    localparam logic             ENABLED   = (STARVE_LIMIT != 0);

    logic [CNT_W-1:0] starve_cnt;

    // Count port-0 wins that overtook a waiting port 1; any port-1 win or an idle edge without REQ1 restarts the count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_cnt <= '0;
        end else if (grant1 || clr) begin
            starve_cnt <= '0;
        end else if (grant0 && req1 && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign force1 = ENABLED && (starve_cnt == THRESHOLD);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the single-ported data memory.
// Port 0 (control unit) has fixed priority, port 1 (DMA/loader) is protected
// by a starvation guard. Each access is a fixed-width read or write strobe
// followed by a one-cycle ACK to the winner. All outputs are registered.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 26,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MEM_LAT      = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              REQ0,
    input  logic              WE0,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [DATA_W-1:0] WDATA0,
    output logic              ACK0,

    input  logic              REQ1,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] WDATA1,
    output logic              ACK1,

    output logic [DATA_W-1:0] RDATA,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DATA_W,
    input  logic [DATA_W-1:0] MEM_DATA_R,
    output logic              BUSY,
    output logic              GRANT_ID
);

    localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(MEM_LAT);

    arb_state_t        state;
    logic [CNT_W-1:0]  lat_cnt;
    logic              lat_we;

    logic              any_req;
    logic              force1;
    logic              win;
    logic              sample;
    logic              grant0;
    logic              grant1;
    logic              clr;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Pick the winner among the live requests and steer its request fields; only used at an IDLE edge.
    always_comb begin
        any_req   = REQ0 | REQ1;
        win       = PORT_CTRL;
        if (REQ1 && (!REQ0 || force1)) begin
            win = PORT_DMA;
        end
        sample    = (state == ARB_IDLE) && any_req;
        grant0    = sample && (win == PORT_CTRL);
        grant1    = sample && (win == PORT_DMA);
        clr       = (state == ARB_IDLE) && !REQ1;
        sel_we    = win ? WE1    : WE0;
        sel_addr  = win ? ADDR1  : ADDR0;
        sel_wdata = win ? WDATA1 : WDATA0;
    end

    mem_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .CLK    (CLK),
        .RST    (RST),
        .grant0 (grant0),
        .grant1 (grant1),
        .req1   (REQ1),
        .clr    (clr),
        .force1 (force1)
    );

    // Access sequencer: latch the winner in IDLE, hold the strobe for MEM_LAT cycles, then pulse the winner's ACK.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ARB_IDLE;
            lat_cnt    <= '0;
            lat_we     <= 1'b0;
            ACK0       <= 1'b0;
            ACK1       <= 1'b0;
            RDATA      <= '0;
            MEM_READ   <= 1'b0;
            MEM_WRITE  <= 1'b0;
            MEM_ADDR   <= '0;
            MEM_DATA_W <= '0;
            BUSY       <= 1'b0;
            GRANT_ID   <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (sample) begin
                        GRANT_ID   <= win;
                        lat_we     <= sel_we;
                        MEM_ADDR   <= sel_addr;
                        MEM_DATA_W <= sel_wdata;
                        MEM_READ   <= !sel_we;
                        MEM_WRITE  <= sel_we;
                        lat_cnt    <= LAT_LOAD;
                        BUSY       <= 1'b1;
                        state      <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    if (lat_cnt == '0) begin
                        if (!lat_we) begin
                            RDATA <= MEM_DATA_R;
                        end
                        MEM_READ  <= 1'b0;
                        MEM_WRITE <= 1'b0;
                        ACK0      <= (GRANT_ID == PORT_CTRL);
                        ACK1      <= (GRANT_ID == PORT_DMA);
                        state     <= ARB_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                ARB_RESP: begin
                    ACK0  <= 1'b0;
                    ACK1  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= ARB_IDLE;
                end
                default: begin
                    MEM_READ  <= 1'b0;
                    MEM_WRITE <= 1'b0;
                    ACK0      <= 1'b0;
                    ACK1      <= 1'b0;
                    BUSY      <= 1'b0;
                    state     <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a random
// two-requester run checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 32;
    localparam int LAT    = 2;
    localparam int STARVE = 4;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              REQ0 = 1'b0, WE0 = 1'b0, REQ1 = 1'b0, WE1 = 1'b0;
    logic [ADDR_W-1:0] ADDR0 = '0, ADDR1 = '0;
    logic [DATA_W-1:0] WDATA0 = '0, WDATA1 = '0;
    logic              ACK0, ACK1, MEM_READ, MEM_WRITE, BUSY, GRANT_ID;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] RDATA, MEM_DATA_W;
    logic [DATA_W-1:0] MEM_DATA_R = '0;

    logic              l1_ack0, l1_ack1, l1_rd, l1_wr, l1_busy, l1_gid;
    logic [ADDR_W-1:0] l1_addr;
    logic [DATA_W-1:0] l1_rdata, l1_wdata;
    logic              l15_ack0, l15_ack1, l15_rd, l15_wr, l15_busy, l15_gid;
    logic [ADDR_W-1:0] l15_addr;
    logic [DATA_W-1:0] l15_rdata, l15_wdata;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] env_mem [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(LAT), .STARVE_LIMIT(STARVE)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .WDATA0(WDATA0), .ACK0(ACK0),
        .REQ1(REQ1), .WE1(WE1), .ADDR1(ADDR1), .WDATA1(WDATA1), .ACK1(ACK1),
        .RDATA(RDATA), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
        .MEM_DATA_W(MEM_DATA_W), .MEM_DATA_R(MEM_DATA_R), .BUSY(BUSY), .GRANT_ID(GRANT_ID)
    );

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(1), .STARVE_LIMIT(STARVE)) dut_l1 (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .WDATA0(WDATA0), .ACK0(l1_ack0),
        .REQ1(REQ1), .WE1(WE1), .ADDR1(ADDR1), .WDATA1(WDATA1), .ACK1(l1_ack1),
        .RDATA(l1_rdata), .MEM_READ(l1_rd), .MEM_WRITE(l1_wr), .MEM_ADDR(l1_addr),
        .MEM_DATA_W(l1_wdata), .MEM_DATA_R(32'h0BAD_F00D), .BUSY(l1_busy), .GRANT_ID(l1_gid)
    );

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(15), .STARVE_LIMIT(STARVE)) dut_l15 (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .WDATA0(WDATA0), .ACK0(l15_ack0),
        .REQ1(REQ1), .WE1(WE1), .ADDR1(ADDR1), .WDATA1(WDATA1), .ACK1(l15_ack1),
        .RDATA(l15_rdata), .MEM_READ(l15_rd), .MEM_WRITE(l15_wr), .MEM_ADDR(l15_addr),
        .MEM_DATA_W(l15_wdata), .MEM_DATA_R(32'h0BAD_F00D), .BUSY(l15_busy), .GRANT_ID(l15_gid)
    );

    // Free-running clock.
    always #5 CLK = ~CLK;

    // Contents of a memory word that was never written.
    function automatic logic [DATA_W-1:0] fill(input logic [ADDR_W-1:0] a);
        return {6'h15, a} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill(a);
    endfunction

    // Memory model read port: data for the current address, settled by mid-cycle.
    always @(negedge CLK) begin
        MEM_DATA_R = env_mem.exists(MEM_ADDR) ? env_mem[MEM_ADDR] : fill(MEM_ADDR);
    end

    // Memory model write port.
    always @(posedge CLK) begin
        if (MEM_WRITE && !RST) env_mem[MEM_ADDR] = MEM_DATA_W;
    end

    task automatic do_reset();
        RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; WE0 = 1'b0; WE1 = 1'b0;
        ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b1; REQ0 = 1'b1; REQ1 = 1'b1; WE1 = 1'b1; ADDR0 = 26'h155; WDATA1 = 32'hFFFF_FFFF;
        for (int c = 1; c <= 3; c++) begin
            @(negedge CLK);
            checks++; if ({ACK0, ACK1, MEM_READ, MEM_WRITE, BUSY, GRANT_ID} !== 6'b0) begin errors++; $display("[TB] FAIL reset_flags c%0d: got %b expected 000000", c, {ACK0, ACK1, MEM_READ, MEM_WRITE, BUSY, GRANT_ID}); end
            checks++; if (MEM_ADDR !== '0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", MEM_ADDR); end
            checks++; if (MEM_DATA_W !== '0) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 0", MEM_DATA_W); end
            checks++; if (RDATA !== '0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", RDATA); end
        end
        do_reset();
    endtask

    task automatic test_read();
        do_reset();
        env_mem[26'h10] = 32'hDEAD_BEEF;
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 26'h10;
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            checks++; if (MEM_READ !== (c <= LAT)) begin errors++; $display("[TB] FAIL read_strobe c%0d: got %b expected %b", c, MEM_READ, c <= LAT); end
            checks++; if (MEM_WRITE !== 1'b0) begin errors++; $display("[TB] FAIL read_nowrite c%0d: got %b expected 0", c, MEM_WRITE); end
            if (c <= LAT) begin
                checks++; if (MEM_ADDR !== 26'h10) begin errors++; $display("[TB] FAIL read_addr c%0d: got %h expected 10", c, MEM_ADDR); end
            end
            checks++; if (ACK0 !== (c == LAT + 1)) begin errors++; $display("[TB] FAIL read_ack0 c%0d: got %b expected %b", c, ACK0, c == LAT + 1); end
            checks++; if (BUSY !== (c <= LAT + 1)) begin errors++; $display("[TB] FAIL read_busy c%0d: got %b expected %b", c, BUSY, c <= LAT + 1); end
            if (c >= LAT + 1) begin
                checks++; if (RDATA !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL read_rdata c%0d: got %h expected deadbeef", c, RDATA); end
            end
            if (c == LAT + 1) REQ0 = 1'b0;
        end
    endtask

    task automatic test_write();
        do_reset();
        REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 26'h3FF_FFFF; WDATA1 = 32'h1234_5678;
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            checks++; if (MEM_WRITE !== (c <= LAT)) begin errors++; $display("[TB] FAIL write_strobe c%0d: got %b expected %b", c, MEM_WRITE, c <= LAT); end
            checks++; if (MEM_READ !== 1'b0) begin errors++; $display("[TB] FAIL write_noread c%0d: got %b expected 0", c, MEM_READ); end
            if (c <= LAT) begin
                checks++; if (MEM_ADDR !== 26'h3FF_FFFF) begin errors++; $display("[TB] FAIL write_addr c%0d: got %h expected 3ffffff", c, MEM_ADDR); end
                checks++; if (MEM_DATA_W !== 32'h1234_5678) begin errors++; $display("[TB] FAIL write_data c%0d: got %h expected 12345678", c, MEM_DATA_W); end
            end
            checks++; if (ACK1 !== (c == LAT + 1)) begin errors++; $display("[TB] FAIL write_ack1 c%0d: got %b expected %b", c, ACK1, c == LAT + 1); end
            checks++; if (ACK0 !== 1'b0) begin errors++; $display("[TB] FAIL write_ack0 c%0d: got %b expected 0", c, ACK0); end
            checks++; if (GRANT_ID !== 1'b1) begin errors++; $display("[TB] FAIL write_gid c%0d: got %b expected 1", c, GRANT_ID); end
            if (c == LAT + 1) begin
                checks++; if (RDATA !== '0) begin errors++; $display("[TB] FAIL write_rdata_untouched: got %h expected 0", RDATA); end
                REQ1 = 1'b0;
            end
        end
    endtask

    task automatic test_tie();
        int seq[$];
        int gids[$];
        do_reset();
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 26'h40;
        REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 26'h41; WDATA1 = 32'hA5A5_5A5A;
        for (int c = 1; c <= 30 && seq.size() < 2; c++) begin
            @(negedge CLK);
            checks++; if (MEM_READ && MEM_WRITE) begin errors++; $display("[TB] FAIL tie_both_strobes c%0d: got 11 expected not both", c); end
            if (ACK0) begin seq.push_back(0); gids.push_back(int'(GRANT_ID)); REQ0 = 1'b0; end
            if (ACK1) begin seq.push_back(1); gids.push_back(int'(GRANT_ID)); REQ1 = 1'b0; end
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        checks++;
        if (seq.size() != 2) begin
            errors++; $display("[TB] FAIL tie_ack_count: got %0d expected 2", seq.size());
        end else if (seq[0] != 0 || seq[1] != 1 || gids[0] != 0 || gids[1] != 1) begin
            errors++; $display("[TB] FAIL tie_order: got ports %0d,%0d gid %0d,%0d expected 0,1 gid 0,1", seq[0], seq[1], gids[0], gids[1]);
        end
    endtask

    task automatic test_starvation();
        int exp_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int seq[$];
        do_reset();
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 26'h50;
        REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 26'h51;
        for (int c = 1; c <= 10 * (LAT + 2) + 10 && seq.size() < 10; c++) begin
            @(negedge CLK);
            if (ACK0) seq.push_back(0);
            if (ACK1) seq.push_back(1);
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        checks++;
        if (seq.size() != 10) begin
            errors++; $display("[TB] FAIL starve_grant_count: got %0d expected 10", seq.size());
        end
        for (int i = 0; i < 10 && i < seq.size(); i++) begin
            checks++; if (seq[i] != exp_seq[i]) begin errors++; $display("[TB] FAIL starve_grant%0d: got port %0d expected port %0d", i, seq[i], exp_seq[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int acks;
        int ack_c;
        do_reset();
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 26'h20;
        @(negedge CLK);
        checks++; if (MEM_READ !== 1'b1) begin errors++; $display("[TB] FAIL rmid_first_access: got %b expected 1", MEM_READ); end
        RST = 1'b1; REQ0 = 1'b0;
        @(negedge CLK);
        checks++; if ({MEM_READ, MEM_WRITE, BUSY, ACK0, ACK1} !== 5'b0) begin errors++; $display("[TB] FAIL rmid_dropped: got %b expected 00000", {MEM_READ, MEM_WRITE, BUSY, ACK0, ACK1}); end
        RST = 1'b0;
        acks = 0;
        repeat (6) begin
            @(negedge CLK);
            if (ACK0 || ACK1 || BUSY) acks++;
        end
        checks++; if (acks != 0) begin errors++; $display("[TB] FAIL rmid_no_ack: got %0d active cycles expected 0", acks); end
        REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 26'h21; WDATA0 = 32'hCAFE_F00D;
        ack_c = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK);
            if (ACK0 && ack_c < 0) begin ack_c = c; REQ0 = 1'b0; end
        end
        REQ0 = 1'b0;
        checks++; if (ack_c != LAT + 1) begin errors++; $display("[TB] FAIL rmid_retry_ack: got cycle %0d expected %0d", ack_c, LAT + 1); end
    endtask

    task automatic test_lat_sweep();
        int lats[3] = '{LAT, 1, 15};
        int nstr[3], first[3], last[3], nack[3], ackc[3];
        logic [2:0] rd, ak;
        do_reset();
        for (int d = 0; d < 3; d++) begin nstr[d] = 0; first[d] = -1; last[d] = -1; nack[d] = 0; ackc[d] = -1; end
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 26'h30;
        for (int c = 1; c <= 20; c++) begin
            @(negedge CLK);
            if (c == 1) REQ0 = 1'b0;
            rd = {l15_rd, l1_rd, MEM_READ};
            ak = {l15_ack0, l1_ack0, ACK0};
            for (int d = 0; d < 3; d++) begin
                if (rd[d]) begin nstr[d]++; if (first[d] < 0) first[d] = c; last[d] = c; end
                if (ak[d]) begin nack[d]++; ackc[d] = c; end
            end
        end
        for (int d = 0; d < 3; d++) begin
            checks++; if (nstr[d] != lats[d] || first[d] != 1 || last[d] != lats[d]) begin errors++; $display("[TB] FAIL sweep_strobe_lat%0d: got %0d cycles (%0d..%0d) expected %0d (1..%0d)", lats[d], nstr[d], first[d], last[d], lats[d], lats[d]); end
            checks++; if (nack[d] != 1 || ackc[d] != lats[d] + 1) begin errors++; $display("[TB] FAIL sweep_ack_lat%0d: got %0d acks at %0d expected 1 at %0d", lats[d], nack[d], ackc[d], lats[d] + 1); end
        end
    endtask

    task automatic test_random();
        bit have_txn = 0;
        int start_e = 0;
        bit t_port = 0, t_we = 0;
        logic [ADDR_W-1:0] t_addr = '0;
        logic [DATA_W-1:0] t_wdata = '0, t_rdata = '0;
        int starve = 0;
        logic [DATA_W-1:0] last_rdata = '0;
        logic last_gid = 1'b0;
        bit pend0 = 0, pend1 = 0;
        bit exp_ack0 = 0, exp_ack1 = 0;
        bit strobe, exp_busy;
        int p0_rate;
        env_mem.delete();
        ref_mem.delete();
        do_reset();
        for (int e = 0; e < 600; e++) begin
            p0_rate = (e >= 300) ? 4 : 1;
            if (exp_ack0) begin REQ0 = 1'b0; pend0 = 0; end
            if (exp_ack1) begin REQ1 = 1'b0; pend1 = 0; end
            if (!pend0 && $urandom_range(0, 3) < p0_rate) begin
                pend0 = 1; REQ0 = 1'b1; WE0 = 1'($urandom_range(0, 1));
                ADDR0 = ADDR_W'($urandom_range(0, 15)); WDATA0 = $urandom;
            end
            if (!pend1 && $urandom_range(0, 3) == 0) begin
                pend1 = 1; REQ1 = 1'b1; WE1 = 1'($urandom_range(0, 1));
                ADDR1 = ADDR_W'($urandom_range(0, 15)); WDATA1 = $urandom;
            end
            @(posedge CLK);
            if (!have_txn || e >= start_e + LAT + 2) begin
                if (REQ0 || REQ1) begin
                    if (REQ0 && REQ1) t_port = (STARVE != 0 && starve == STARVE);
                    else t_port = REQ1;
                    if (!t_port && REQ1) starve = (starve < 15) ? starve + 1 : 15;
                    if (t_port) starve = 0;
                    t_we    = t_port ? WE1 : WE0;
                    t_addr  = t_port ? ADDR1 : ADDR0;
                    t_wdata = t_port ? WDATA1 : WDATA0;
                    if (t_we) ref_mem[t_addr] = t_wdata;
                    else t_rdata = ref_rd(t_addr);
                    start_e = e; have_txn = 1; last_gid = t_port;
                end
                if (!REQ1) starve = 0;
            end
            if (have_txn && e == start_e + LAT && !t_we) last_rdata = t_rdata;
            @(negedge CLK);
            strobe   = have_txn && e >= start_e && e <= start_e + LAT - 1;
            exp_busy = have_txn && e >= start_e && e <= start_e + LAT;
            exp_ack0 = have_txn && e == start_e + LAT && !t_port;
            exp_ack1 = have_txn && e == start_e + LAT && t_port;
            checks++; if (MEM_READ !== (strobe && !t_we)) begin errors++; $display("[TB] FAIL rnd_mem_read e%0d: got %b expected %b", e, MEM_READ, strobe && !t_we); end
            checks++; if (MEM_WRITE !== (strobe && t_we)) begin errors++; $display("[TB] FAIL rnd_mem_write e%0d: got %b expected %b", e, MEM_WRITE, strobe && t_we); end
            checks++; if (ACK0 !== exp_ack0) begin errors++; $display("[TB] FAIL rnd_ack0 e%0d: got %b expected %b", e, ACK0, exp_ack0); end
            checks++; if (ACK1 !== exp_ack1) begin errors++; $display("[TB] FAIL rnd_ack1 e%0d: got %b expected %b", e, ACK1, exp_ack1); end
            checks++; if (BUSY !== exp_busy) begin errors++; $display("[TB] FAIL rnd_busy e%0d: got %b expected %b", e, BUSY, exp_busy); end
            checks++; if (GRANT_ID !== last_gid) begin errors++; $display("[TB] FAIL rnd_grant_id e%0d: got %b expected %b", e, GRANT_ID, last_gid); end
            checks++; if (RDATA !== last_rdata) begin errors++; $display("[TB] FAIL rnd_rdata e%0d: got %h expected %h", e, RDATA, last_rdata); end
            if (strobe) begin
                checks++; if (MEM_ADDR !== t_addr) begin errors++; $display("[TB] FAIL rnd_mem_addr e%0d: got %h expected %h", e, MEM_ADDR, t_addr); end
                checks++; if (MEM_DATA_W !== t_wdata) begin errors++; $display("[TB] FAIL rnd_mem_data_w e%0d: got %h expected %h", e, MEM_DATA_W, t_wdata); end
            end
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
    endtask

    // Scenario sequence and final summary.
    initial begin
        $display("[TB] start");
        test_reset();
        test_read();
        test_write();
        test_tie();
        test_starvation();
        test_reset_mid();
        test_lat_sweep();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
